// File: rtl/alu_control_fsm_if.sv
// Control bundle between the ALU control FSM (master) and the datapath/memory side (slave).
interface alu_control_fsm_if #(
   parameter int INSTR_W = 16,
   parameter int RA_W    = 2
);
   logic               start;
   logic [INSTR_W-1:0] instr;
   logic               mem_ready;
   logic               mem_req;
   logic               mem_we;
   logic               mem_sel_data;
   logic               ir_load;
   logic               pc_inc;
   logic [2:0]         alu_opcode;
   logic               alu_out_ld;
   logic [RA_W-1:0]    rf_raddr_a;
   logic [RA_W-1:0]    rf_raddr_b;
   logic [RA_W-1:0]    rf_waddr;
   logic               rf_we;
   logic               wb_from_mem;
   logic               busy;
   logic               halted;
   logic               illegal;

   modport master (
      input  start, instr, mem_ready,
      output mem_req, mem_we, mem_sel_data, ir_load, pc_inc, alu_opcode, alu_out_ld,
             rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, wb_from_mem, busy, halted, illegal
   );

   modport slave (
      output start, instr, mem_ready,
      input  mem_req, mem_we, mem_sel_data, ir_load, pc_inc, alu_opcode, alu_out_ld,
             rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, wb_from_mem, busy, halted, illegal
   );
endinterface

// File: rtl/alu_control_fsm.sv
// Multi-cycle fetch/decode/execute/mem/write-back sequencer for a 16-bit ALU datapath.
// Zero-wait latency: ADD/SUB 4, LOAD 5, STORE 4, NOP 2; memory stalls by holding in FETCH/MEM until mem_ready.
module alu_control_fsm #(
   parameter int INSTR_W = 16,
   parameter int RA_W    = 2
) (
   input logic              clk,
   input logic              rst_n,
   alu_control_fsm_if.master bus
);
   localparam int OP_HI = INSTR_W - 1;
   localparam int RD_HI = INSTR_W - 4;
   localparam int RS_HI = RD_HI - RA_W;
   localparam int RT_HI = RS_HI - RA_W;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_LOAD  = 3'b100;
   localparam logic [2:0] OP_STORE = 3'b101;
   localparam logic [2:0] OP_NOP   = 3'b110;
   localparam logic [2:0] OP_HALT  = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
   } state_t;

   typedef struct packed {
      logic            mem_req;
      logic            mem_we;
      logic            mem_sel_data;
      logic [2:0]      alu_opcode;
      logic            alu_out_ld;
      logic [RA_W-1:0] rf_raddr_a;
      logic [RA_W-1:0] rf_raddr_b;
      logic [RA_W-1:0] rf_waddr;
      logic            rf_we;
      logic            wb_from_mem;
      logic            busy;
      logic            halted;
   } ctl_t;

   state_t             state, nxt_state;
   logic [INSTR_W-1:0] ir, nxt_ir;
   logic               illegal_flag, nxt_illegal;
   ctl_t               ctl, nxt_ctl;

   logic [2:0]      op, n_op;
   logic [RA_W-1:0] n_rd, n_rs, n_rt;
   logic            unused_ir_bits;

   assign op   = ir[OP_HI -: 3];
   assign n_op = nxt_ir[OP_HI -: 3];
   assign n_rd = nxt_ir[RD_HI -: RA_W];
   assign n_rs = nxt_ir[RS_HI -: RA_W];
   assign n_rt = nxt_ir[RT_HI -: RA_W];
   assign unused_ir_bits = ^{ir[RT_HI-RA_W:0], nxt_ir[RT_HI-RA_W:0]};

   always_comb begin
      nxt_state   = state;
      nxt_ir      = ir;
      nxt_illegal = illegal_flag;
      case (state)
         S_IDLE:   if (bus.start) nxt_state = S_FETCH;
         S_FETCH:  if (bus.mem_ready) begin
                      nxt_ir    = bus.instr;
                      nxt_state = S_DECODE;
                   end
         S_DECODE: case (op)
                      OP_ADD, OP_SUB, OP_LOAD, OP_STORE: nxt_state = S_EXEC;
                      OP_NOP:  nxt_state = S_FETCH;
                      OP_HALT: nxt_state = S_HALTED;
                      default: begin
                         nxt_illegal = 1'b1;
                         nxt_state   = S_HALTED;
                      end
                   endcase
         S_EXEC:   nxt_state = (op == OP_ADD || op == OP_SUB) ? S_WB : S_MEM;
         S_MEM:    if (bus.mem_ready) nxt_state = (op == OP_STORE) ? S_FETCH : S_WB;
         S_WB:     nxt_state = S_FETCH;
         S_HALTED: nxt_state = S_HALTED;
         default:  nxt_state = S_IDLE;
      endcase
   end

   // Moore outputs are decoded from the next state so the registered copy matches the state it describes.
   always_comb begin
      nxt_ctl = '0;
      case (nxt_state)
         S_FETCH:  nxt_ctl.mem_req = 1'b1;
         S_DECODE: begin
            nxt_ctl.rf_raddr_a = n_rs;
            nxt_ctl.rf_raddr_b = n_rt;
         end
         S_EXEC: begin
            nxt_ctl.alu_opcode = n_op;
            nxt_ctl.rf_raddr_a = n_rs;
            nxt_ctl.rf_raddr_b = n_rt;
            nxt_ctl.alu_out_ld = 1'b1;
         end
         S_MEM: begin
            nxt_ctl.mem_req      = 1'b1;
            nxt_ctl.mem_sel_data = 1'b1;
            nxt_ctl.mem_we       = (n_op == OP_STORE);
            nxt_ctl.rf_raddr_a   = n_rd;
         end
         S_WB: begin
            nxt_ctl.rf_we       = 1'b1;
            nxt_ctl.rf_waddr    = n_rd;
            nxt_ctl.wb_from_mem = (n_op == OP_LOAD);
         end
         S_HALTED: nxt_ctl.halted = 1'b1;
         default:  nxt_ctl = '0;
      endcase
      nxt_ctl.busy = (nxt_state != S_IDLE) && (nxt_state != S_HALTED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         ir           <= '0;
         illegal_flag <= 1'b0;
         ctl          <= '0;
      end else begin
         state        <= nxt_state;
         ir           <= nxt_ir;
         illegal_flag <= nxt_illegal;
         ctl          <= nxt_ctl;
      end
   end

   // IR load and PC increment fire in the same cycle the fetch completes.
   assign bus.ir_load      = (state == S_FETCH) && bus.mem_ready;
   assign bus.pc_inc       = (state == S_FETCH) && bus.mem_ready;
   assign bus.mem_req      = ctl.mem_req;
   assign bus.mem_we       = ctl.mem_we;
   assign bus.mem_sel_data = ctl.mem_sel_data;
   assign bus.alu_opcode   = ctl.alu_opcode;
   assign bus.alu_out_ld   = ctl.alu_out_ld;
   assign bus.rf_raddr_a   = ctl.rf_raddr_a;
   assign bus.rf_raddr_b   = ctl.rf_raddr_b;
   assign bus.rf_waddr     = ctl.rf_waddr;
   assign bus.rf_we        = ctl.rf_we;
   assign bus.wb_from_mem  = ctl.wb_from_mem;
   assign bus.busy         = ctl.busy;
   assign bus.halted       = ctl.halted;
   assign bus.illegal      = illegal_flag;
endmodule

// File: tb/tb_alu_control_fsm.sv
// Directed-vector bench for alu_control_fsm: per-cycle output vectors checked on the falling edge.
module tb_alu_control_fsm;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   alu_control_fsm_if #(.INSTR_W(16), .RA_W(2)) bus ();
   alu_control_fsm #(.INSTR_W(16), .RA_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [19:0] obs;
   assign obs = {bus.mem_req, bus.mem_we, bus.mem_sel_data, bus.ir_load, bus.pc_inc,
                 bus.alu_opcode, bus.alu_out_ld, bus.rf_raddr_a, bus.rf_raddr_b,
                 bus.rf_waddr, bus.rf_we, bus.wb_from_mem, bus.busy, bus.halted, bus.illegal};

   typedef struct {
      logic        s;
      logic        r;
      logic [15:0] i;
      logic [19:0] e;
   } row_t;

   function automatic logic [19:0] pk(logic mreq, logic mwe, logic msel, logic irl, logic pci,
                                      logic [2:0] aop, logic aold, logic [1:0] ra, logic [1:0] rb,
                                      logic [1:0] wa, logic we, logic wbm, logic bsy, logic hlt,
                                      logic ill);
      return {mreq, mwe, msel, irl, pci, aop, aold, ra, rb, wa, we, wbm, bsy, hlt, ill};
   endfunction

   function automatic logic [19:0] e_idle();
      return pk('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
   endfunction
   function automatic logic [19:0] e_fetch(logic rdy);
      return pk('1, '0, '0, rdy, rdy, '0, '0, '0, '0, '0, '0, '0, '1, '0, '0);
   endfunction
   function automatic logic [19:0] e_dec(logic [1:0] ra, logic [1:0] rb);
      return pk('0, '0, '0, '0, '0, '0, '0, ra, rb, '0, '0, '0, '1, '0, '0);
   endfunction
   function automatic logic [19:0] e_exec(logic [2:0] op, logic [1:0] ra, logic [1:0] rb);
      return pk('0, '0, '0, '0, '0, op, '1, ra, rb, '0, '0, '0, '1, '0, '0);
   endfunction
   function automatic logic [19:0] e_mem(logic we, logic [1:0] rd);
      return pk('1, we, '1, '0, '0, '0, '0, rd, '0, '0, '0, '0, '1, '0, '0);
   endfunction
   function automatic logic [19:0] e_wb(logic [1:0] rd, logic wbm);
      return pk('0, '0, '0, '0, '0, '0, '0, '0, '0, rd, '1, wbm, '1, '0, '0);
   endfunction
   function automatic logic [19:0] e_halt(logic ill);
      return pk('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '1, ill);
   endfunction

   function automatic row_t rw(logic s, logic r, logic [15:0] i, logic [19:0] e);
      row_t x;
      x.s = s; x.r = r; x.i = i; x.e = e;
      return x;
   endfunction

   // One cycle: inputs change just after the rising edge, outputs are sampled on the falling edge.
   task automatic cyc(input logic s, input logic r, input logic [15:0] i);
      @(posedge clk); #1;
      bus.start     = s;
      bus.mem_ready = r;
      bus.instr     = i;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.mem_ready = 1'b0;
      bus.instr     = '0;
      rst_n         = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.start     = 1'b0;
      bus.mem_ready = 1'b0;
      bus.instr     = '0;
      rst_n         = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== e_idle()) begin
         errors++;
         $display("FAIL reset_hold: got %05h exp %05h", obs, e_idle());
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cyc(1'b0, 1'b1, 16'h0D80);
         checks++;
         if (obs !== e_idle()) begin
            errors++;
            $display("FAIL reset_idle cyc%0d: got %05h exp %05h", k, obs, e_idle());
         end
      end
   endtask

   task automatic test_add();
      row_t rows[$];
      do_reset();
      rows.push_back(rw(1'b1, 1'b1, 16'h0D80, e_idle()));
      rows.push_back(rw(1'b0, 1'b1, 16'h0D80, e_fetch(1'b1)));
      rows.push_back(rw(1'b0, 1'b1, 16'hC000, e_dec(2'd2, 2'd3)));
      rows.push_back(rw(1'b0, 1'b1, 16'hC000, e_exec(3'b000, 2'd2, 2'd3)));
      rows.push_back(rw(1'b0, 1'b1, 16'hC000, e_wb(2'd1, 1'b0)));
      rows.push_back(rw(1'b0, 1'b1, 16'hC000, e_fetch(1'b1)));
      foreach (rows[k]) begin
         cyc(rows[k].s, rows[k].r, rows[k].i);
         checks++;
         if (obs !== rows[k].e) begin
            errors++;
            $display("FAIL add cyc%0d: got %05h exp %05h", k, obs, rows[k].e);
         end
      end
   endtask

   task automatic test_load_wait();
      row_t rows[$];
      do_reset();
      rows.push_back(rw(1'b1, 1'b1, 16'h9200, e_idle()));
      rows.push_back(rw(1'b0, 1'b1, 16'h9200, e_fetch(1'b1)));
      rows.push_back(rw(1'b0, 1'b1, 16'h9200, e_dec(2'd1, 2'd0)));
      rows.push_back(rw(1'b0, 1'b0, 16'h9200, e_exec(3'b100, 2'd1, 2'd0)));
      rows.push_back(rw(1'b0, 1'b0, 16'h9200, e_mem(1'b0, 2'd2)));
      rows.push_back(rw(1'b0, 1'b0, 16'h9200, e_mem(1'b0, 2'd2)));
      rows.push_back(rw(1'b0, 1'b0, 16'h9200, e_mem(1'b0, 2'd2)));
      rows.push_back(rw(1'b0, 1'b1, 16'h9200, e_mem(1'b0, 2'd2)));
      rows.push_back(rw(1'b0, 1'b0, 16'h9200, e_wb(2'd2, 1'b1)));
      rows.push_back(rw(1'b0, 1'b0, 16'h9200, e_fetch(1'b0)));
      foreach (rows[k]) begin
         cyc(rows[k].s, rows[k].r, rows[k].i);
         checks++;
         if (obs !== rows[k].e) begin
            errors++;
            $display("FAIL load_wait cyc%0d: got %05h exp %05h", k, obs, rows[k].e);
         end
      end
   endtask

   task automatic test_store();
      row_t rows[$];
      do_reset();
      rows.push_back(rw(1'b1, 1'b1, 16'hB880, e_idle()));
      rows.push_back(rw(1'b0, 1'b1, 16'hB880, e_fetch(1'b1)));
      rows.push_back(rw(1'b0, 1'b1, 16'hB880, e_dec(2'd0, 2'd1)));
      rows.push_back(rw(1'b0, 1'b1, 16'hB880, e_exec(3'b101, 2'd0, 2'd1)));
      rows.push_back(rw(1'b0, 1'b1, 16'hB880, e_mem(1'b1, 2'd3)));
      rows.push_back(rw(1'b0, 1'b0, 16'hB880, e_fetch(1'b0)));
      foreach (rows[k]) begin
         cyc(rows[k].s, rows[k].r, rows[k].i);
         checks++;
         if (obs !== rows[k].e) begin
            errors++;
            $display("FAIL store cyc%0d: got %05h exp %05h", k, obs, rows[k].e);
         end
      end
   endtask

   task automatic test_back_to_back();
      row_t rows[$];
      int   pc_cnt = 0;
      do_reset();
      rows.push_back(rw(1'b1, 1'b1, 16'h3680, e_idle()));
      rows.push_back(rw(1'b0, 1'b1, 16'h3680, e_fetch(1'b1)));
      rows.push_back(rw(1'b0, 1'b1, 16'hC000, e_dec(2'd3, 2'd1)));
      rows.push_back(rw(1'b0, 1'b1, 16'hC000, e_exec(3'b001, 2'd3, 2'd1)));
      rows.push_back(rw(1'b0, 1'b1, 16'hC000, e_wb(2'd2, 1'b0)));
      rows.push_back(rw(1'b0, 1'b1, 16'hC000, e_fetch(1'b1)));
      rows.push_back(rw(1'b0, 1'b1, 16'hE000, e_dec(2'd0, 2'd0)));
      rows.push_back(rw(1'b0, 1'b1, 16'hE000, e_fetch(1'b1)));
      rows.push_back(rw(1'b0, 1'b1, 16'hE000, e_dec(2'd0, 2'd0)));
      rows.push_back(rw(1'b1, 1'b1, 16'hE000, e_halt(1'b0)));
      rows.push_back(rw(1'b0, 1'b1, 16'h0D80, e_halt(1'b0)));
      rows.push_back(rw(1'b1, 1'b0, 16'h0D80, e_halt(1'b0)));
      foreach (rows[k]) begin
         cyc(rows[k].s, rows[k].r, rows[k].i);
         if (bus.pc_inc === 1'b1) pc_cnt++;
         checks++;
         if (obs !== rows[k].e) begin
            errors++;
            $display("FAIL stream cyc%0d: got %05h exp %05h", k, obs, rows[k].e);
         end
      end
      checks++;
      if (pc_cnt !== 3) begin
         errors++;
         $display("FAIL stream_pc_inc: got %0d exp 3", pc_cnt);
      end
   endtask

   task automatic test_illegal();
      row_t rows[$];
      do_reset();
      rows.push_back(rw(1'b1, 1'b1, 16'h4000, e_idle()));
      rows.push_back(rw(1'b0, 1'b1, 16'h4000, e_fetch(1'b1)));
      rows.push_back(rw(1'b0, 1'b1, 16'h4000, e_dec(2'd0, 2'd0)));
      rows.push_back(rw(1'b1, 1'b1, 16'h4000, e_halt(1'b1)));
      rows.push_back(rw(1'b0, 1'b1, 16'h4000, e_halt(1'b1)));
      foreach (rows[k]) begin
         cyc(rows[k].s, rows[k].r, rows[k].i);
         checks++;
         if (obs !== rows[k].e) begin
            errors++;
            $display("FAIL illegal cyc%0d: got %05h exp %05h", k, obs, rows[k].e);
         end
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== e_idle()) begin
         errors++;
         $display("FAIL illegal_clear: got %05h exp %05h", obs, e_idle());
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== e_idle()) begin
         errors++;
         $display("FAIL illegal_after_release: got %05h exp %05h", obs, e_idle());
      end
   endtask

   task automatic test_reset_mid_mem();
      row_t rows[$];
      row_t post[$];
      do_reset();
      rows.push_back(rw(1'b1, 1'b1, 16'h9200, e_idle()));
      rows.push_back(rw(1'b0, 1'b1, 16'h9200, e_fetch(1'b1)));
      rows.push_back(rw(1'b0, 1'b1, 16'h9200, e_dec(2'd1, 2'd0)));
      rows.push_back(rw(1'b0, 1'b0, 16'h9200, e_exec(3'b100, 2'd1, 2'd0)));
      rows.push_back(rw(1'b0, 1'b0, 16'h9200, e_mem(1'b0, 2'd2)));
      foreach (rows[k]) begin
         cyc(rows[k].s, rows[k].r, rows[k].i);
         checks++;
         if (obs !== rows[k].e) begin
            errors++;
            $display("FAIL mid_mem cyc%0d: got %05h exp %05h", k, obs, rows[k].e);
         end
      end
      // Reset lands between edges while the load is stalled; outputs must drop without a clock.
      #2 rst_n = 1'b0;
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (obs !== e_idle()) begin
         errors++;
         $display("FAIL mid_mem_async: got %05h exp %05h", obs, e_idle());
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      post.push_back(rw(1'b0, 1'b1, 16'h9200, e_idle()));
      post.push_back(rw(1'b0, 1'b1, 16'h9200, e_idle()));
      post.push_back(rw(1'b1, 1'b1, 16'h9200, e_idle()));
      post.push_back(rw(1'b0, 1'b0, 16'h9200, e_fetch(1'b0)));
      post.push_back(rw(1'b0, 1'b1, 16'h9200, e_fetch(1'b1)));
      foreach (post[k]) begin
         cyc(post[k].s, post[k].r, post[k].i);
         checks++;
         if (obs !== post[k].e) begin
            errors++;
            $display("FAIL after_mid_mem cyc%0d: got %05h exp %05h", k, obs, post[k].e);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_add();
      test_load_wait();
      test_store();
      test_back_to_back();
      test_illegal();
      test_reset_mid_mem();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
